// File: rtl/npc_lsu_pkg.sv
// Shared types and decode helpers for the NPC load/store unit.
// Holds the FSM state encoding and funct3 size/legality checks.
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // log2 of the access size in bytes
    function automatic logic [1:0] lsu_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic lsu_illegal(input logic wen,
                                         input logic [2:0] f3,
                                         input logic rv64);
        return (f3 == 3'b111) || (wen && f3[2]) ||
               (!rv64 && (f3 == LD || f3 == LWU));
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3,
                                            input logic [2:0] a);
        logic m;
        unique case (lsu_size(f3))
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = |a[1:0];
            default: m = |a[2:0];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering for the LSU: store shift, byte mask,
// and load extract with sign or zero extension.
module npc_lsu_align
    import npc_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       funct3_i,
    input  logic             wen_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  lane_wdata_o,
    output logic [NB-1:0]    wmask_o,
    output logic [XLEN-1:0]  load_o
);

    logic [NB-1:0]          base;
    logic [XLEN-1:0]        sh;
    logic [OFF_W+2:0]       bit_off;
    logic                   sx;

    assign bit_off      = {off_i, 3'b000};
    assign lane_wdata_o = wdata_i << bit_off;
    assign wmask_o      = wen_i ? (base << off_i) : '0;
    assign sh           = rdata_i >> bit_off;
    assign sx           = ~funct3_i[2];

    // Unshifted byte mask: one bit per byte of the access size
    always_comb begin
        base = '0;
        for (int i = 0; i < NB; i++) begin
            base[i] = (i < (1 << lsu_size(funct3_i)));
        end
    end

    // Truncate the shifted word to the access size and extend it
    always_comb begin
        load_o = sh;
        unique case (lsu_size(funct3_i))
            2'b00: begin
                if (sx) load_o = XLEN'($signed(sh[7:0]));
                else    load_o = XLEN'(sh[7:0]);
            end
            2'b01: begin
                if (sx) load_o = XLEN'($signed(sh[15:0]));
                else    load_o = XLEN'(sh[15:0]);
            end
            2'b10: begin
                if (sx) load_o = XLEN'($signed(sh[31:0]));
                else    load_o = XLEN'(sh[31:0]);
            end
            default: load_o = sh;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit for the NPC core.
// One request in flight; traps bad accesses and memory timeouts.
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_resp_rdata
);

    localparam int   NB    = XLEN / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam logic RV64  = (XLEN == 64);

    lsu_state_e             state_q, state_d;
    logic                   wen_q, wen_d;
    logic [2:0]             f3_q, f3_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   mwen_q, mwen_d;
    logic [ADDR_W-1:0]      maddr_q, maddr_d;
    logic [XLEN-1:0]        mwdata_q, mwdata_d;
    logic [NB-1:0]          mwmask_q, mwmask_d;

    logic                   idle;
    logic                   bad;
    logic [OFF_W-1:0]       al_off;
    logic [2:0]             al_f3;
    logic [XLEN-1:0]        al_wdata;
    logic [NB-1:0]          al_wmask;
    logic [XLEN-1:0]        al_load;

    assign idle   = (state_q == S_IDLE);
    assign bad    = lsu_illegal(req_wen, req_funct3, RV64) ||
                    lsu_misaligned(req_funct3, req_addr[2:0]);
    // One aligner: incoming request while idle, latched access after
    assign al_off = idle ? req_addr[OFF_W-1:0] : off_q;
    assign al_f3  = idle ? req_funct3 : f3_q;

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .off_i        (al_off),
        .funct3_i     (al_f3),
        .wen_i        (req_wen),
        .wdata_i      (req_wdata),
        .rdata_i      (mem_resp_rdata),
        .lane_wdata_o (al_wdata),
        .wmask_o      (al_wmask),
        .load_o       (al_load)
    );

    assign req_ready     = idle;
    assign resp_valid    = (state_q == S_RESP);
    assign mem_req_valid = (state_q == S_REQ);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_req_wen   = mwen_q;
    assign mem_req_addr  = maddr_q;
    assign mem_req_wdata = mwdata_q;
    assign mem_req_wmask = mwmask_q;

    // Next-state, timeout counter and result capture
    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        f3_d     = f3_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mwen_d   = mwen_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwmask_d = mwmask_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    f3_d    = req_funct3;
                    off_d   = req_addr[OFF_W-1:0];
                    rdata_d = '0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = S_RESP;
                    end else begin
                        state_d  = S_REQ;
                        mwen_d   = req_wen;
                        maddr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mwdata_d = al_wdata;
                        mwmask_d = al_wmask;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RESP;
                    rdata_d = wen_q ? '0 : al_load;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == '1) begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wen_q    <= 1'b0;
            f3_q     <= 3'b0;
            off_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mwen_q   <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwmask_q <= '0;
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mwen_q   <= mwen_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwmask_q <= mwmask_d;
        end
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Self-checking bench for npc_lsu: directed cases plus random
// traffic on an RV32 instance, directed cases on an RV64 instance.
module tb_npc_lsu;
    import npc_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // RV32 instance
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_W(4)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    // RV64 instance
    logic        w_req_valid, w_req_ready, w_req_wen;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_resp_valid, w_resp_ready, w_resp_err;
    logic [63:0] w_resp_rdata;
    logic        w_mem_req_valid, w_mem_req_ready, w_mem_req_wen;
    logic [31:0] w_mem_req_addr;
    logic [63:0] w_mem_req_wdata;
    logic [7:0]  w_mem_req_wmask;
    logic        w_mem_resp_valid;
    logic [63:0] w_mem_resp_rdata;

    npc_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_W(4)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_wen(w_req_wen), .req_funct3(w_req_funct3),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
        .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
        .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
        .mem_req_wen(w_mem_req_wen), .mem_req_addr(w_mem_req_addr),
        .mem_req_wdata(w_mem_req_wdata), .mem_req_wmask(w_mem_req_wmask),
        .mem_resp_valid(w_mem_resp_valid), .mem_resp_rdata(w_mem_resp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of one RV32 access, from the access rules
    function automatic void model(input bit wen, input bit [2:0] f3,
                                  input bit [31:0] addr, wdata, mword,
                                  output bit bad, output bit [31:0] xaddr,
                                  output bit [31:0] xwdata,
                                  output bit [3:0] xmask,
                                  output bit [31:0] xload);
        int sz;
        int off;
        longint unsigned v;
        longint unsigned m;
        sz  = 1 << f3[1:0];
        off = int'(addr % 4);
        bad = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wen && f3 >= 4) ||
              (addr % sz != 0);
        xaddr  = addr & ~32'h3;
        xmask  = wen ? 4'(((1 << sz) - 1) << off) : 4'h0;
        xwdata = wdata << (8 * off);
        m = (sz >= 8) ? ~64'd0 : ((64'd1 << (8 * sz)) - 1);
        v = (64'(mword) >> (8 * off)) & m;
        if (f3 < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~m;
        xload = wen ? 32'h0 : v[31:0];
    endfunction

    task automatic txn(input bit wen, input bit [2:0] f3,
                       input bit [31:0] addr, wdata, mword,
                       input int rdly, wdly, input bit noresp,
                       input int hold);
        bit        bad;
        bit [31:0] xaddr, xwdata, xload, erd;
        bit [3:0]  xmask;
        bit        eerr;
        int        waits;
        model(wen, f3, addr, wdata, mword, bad, xaddr, xwdata, xmask, xload);
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        req_valid = 1; req_wen = wen; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
        if (bad) begin
            chk("bad_no_mreq", mem_req_valid, 0);
        end else begin
            chk("mreq", {mem_req_valid, mem_req_wen, mem_req_addr,
                         mem_req_wmask}, {1'b1, wen, xaddr, xmask});
            if (wen) chk("mreq_wdata", mem_req_wdata, xwdata);
            for (int i = 0; i < rdly; i++) begin
                mem_resp_valid = 1'($urandom % 2);
                mem_resp_rdata = $urandom;
                @(negedge clk);
                chk("mreq_hold", {mem_req_valid, mem_req_addr, mem_req_wmask},
                    {1'b1, xaddr, xmask});
            end
            mem_resp_valid = 0; mem_req_ready = 1;
            @(negedge clk);
            mem_req_ready = 0;
            chk("mreq_drop", {mem_req_valid, resp_valid}, 2'b00);
            if (noresp) begin
                waits = 0;
                while (!resp_valid && waits < 40) begin
                    @(negedge clk);
                    waits++;
                end
                chk("timeout_cycles", waits, 15);
            end else begin
                repeat (wdly) @(negedge clk);
                mem_resp_valid = 1; mem_resp_rdata = mword;
                @(negedge clk);
                mem_resp_valid = 0; mem_resp_rdata = $urandom;
            end
        end
        eerr = bad || noresp;
        erd  = eerr ? 32'h0 : xload;
        chk("resp", {resp_valid, req_ready, resp_err, resp_rdata},
            {1'b1, 1'b0, eerr, erd});
        for (int i = 0; i < hold; i++) begin
            mem_resp_valid = 1'($urandom % 2);
            mem_resp_rdata = $urandom;
            @(negedge clk);
            chk("resp_hold", {resp_valid, req_ready, resp_err, resp_rdata},
                {1'b1, 1'b0, eerr, erd});
        end
        mem_resp_valid = 0; resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk("resp_done", {resp_valid, req_ready}, 2'b01);
    endtask

    // RV64 access against a ready memory; also checks 3-cycle latency
    task automatic txn64(input bit wen, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [63:0] wdata,
                         input bit [63:0] mword, input bit eerr,
                         input bit [31:0] xaddr, input bit [7:0] xmask,
                         input bit [63:0] xwdata, input bit [63:0] xload);
        @(negedge clk);
        w_req_valid = 1; w_req_wen = wen; w_req_funct3 = f3;
        w_req_addr = addr; w_req_wdata = wdata;
        @(negedge clk);
        w_req_valid = 0;
        if (!eerr) begin
            chk("w_mreq", {w_mem_req_valid, w_mem_req_wen, w_mem_req_addr,
                           w_mem_req_wmask}, {1'b1, wen, xaddr, xmask});
            if (wen) chk("w_mreq_wdata", w_mem_req_wdata, xwdata);
            @(negedge clk);
            chk("w_wait", {w_mem_req_valid, w_resp_valid}, 2'b00);
            w_mem_resp_valid = 1; w_mem_resp_rdata = mword;
            @(negedge clk);
            w_mem_resp_valid = 0;
        end
        chk("w_resp_valid", w_resp_valid, 1);
        chk("w_resp_err", w_resp_err, eerr);
        chk("w_resp_rdata", w_resp_rdata, eerr ? 64'h0 : xload);
        w_resp_ready = 1;
        @(negedge clk);
        w_resp_ready = 0;
        chk("w_resp_done", {w_resp_valid, w_req_ready}, 2'b01);
    endtask

    initial begin
        bit [2:0]  f3;
        bit        wen;
        bit [31:0] addr;
        rst = 0;
        req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; resp_ready = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_rdata = 0;
        w_req_valid = 0; w_req_wen = 0; w_req_funct3 = 0; w_req_addr = 0;
        w_req_wdata = 0; w_resp_ready = 0; w_mem_req_ready = 1;
        w_mem_resp_valid = 0; w_mem_resp_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {req_ready, resp_valid, resp_err, mem_req_valid,
                        mem_req_wen, mem_req_wmask}, 9'b1_0000_0000);
        chk("rst_data", {resp_rdata, mem_req_addr}, 64'h0);
        chk("rst_wdata", mem_req_wdata, 0);
        rst = 1;

        txn(0, LB, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 2, 0, 1);
        txn(1, SH, 32'h8000_0002, 32'h0000_ABCD, 32'h1111_2222, 1, 0, 0, 0);
        txn(0, LW, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 1);
        txn(0, LWU, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
        txn(0, LD, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
        txn(1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
        txn(0, LW, 32'h8000_0004, 32'h0, 32'h0, 0, 0, 1, 2);
        txn(0, LHU, 32'h8000_0002, 32'h0, 32'h8765_4321, 2, 1, 0, 0);

        // Reset pulse while waiting for memory
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_funct3 = LW; req_addr = 32'h8000_0008;
        @(negedge clk);
        req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        #2 rst = 0;
        #1;
        chk("mid_rst_ctl", {req_ready, resp_valid, resp_err, mem_req_valid,
                            mem_req_wen, mem_req_wmask}, 9'b1_0000_0000);
        chk("mid_rst_data", {resp_rdata, mem_req_addr}, 64'h0);
        chk("mid_rst_wdata", mem_req_wdata, 0);
        @(negedge clk);
        rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 0;
        chk("post_rst_resp", {resp_valid, req_ready, mem_req_valid}, 3'b010);
        @(negedge clk);
        chk("post_rst_idle", {resp_valid, req_ready}, 2'b01);

        for (int n = 0; n < 80; n++) begin
            wen = 1'($urandom % 3 == 0);
            if ($urandom % 8 == 0) f3 = 3'($urandom);
            else if (wen) f3 = 3'($urandom % 3);
            else begin
                f3 = 3'($urandom % 5);
                if (f3 == 3) f3 = LBU;
                if (f3 == 4) f3 = LHU;
            end
            addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
            if ($urandom % 3 == 0) addr = addr | ($urandom % 4);
            else addr = addr | (($urandom % 4) & ~((1 << f3[1:0]) - 1));
            txn(wen, f3, addr, $urandom, $urandom, int'($urandom % 3),
                int'($urandom % 4), 1'($urandom % 20 == 0),
                int'($urandom % 3));
        end

        txn64(0, LWU, 32'h4, 64'h0, 64'hF000_0000_0000_0000, 0,
              32'h0, 8'h00, 64'h0, 64'h0000_0000_F000_0000);
        txn64(0, LW, 32'h4, 64'h0, 64'hF000_0000_0000_0000, 0,
              32'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_F000_0000);
        txn64(0, LD, 32'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 0,
              32'h8, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF);
        txn64(1, SW, 32'h14, 64'h0000_0000_1234_5678, 64'h0, 0,
              32'h10, 8'hF0, 64'h1234_5678_0000_0000, 64'h0);
        txn64(1, SD, 32'h18, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 0,
              32'h18, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, 64'h0);
        txn64(0, LD, 32'h4, 64'h0, 64'h0, 1,
              32'h0, 8'h00, 64'h0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
